// File: rtl/word_pkg.sv
// Shared constants, FSM state type and byte classification for the ASCII word packer.
package word_pkg;

  localparam int MAX_CHARS_DEFAULT = 10;
  localparam int LEN_W             = 4;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {ACCUM, EMIT_WORD, EMIT_DELIM} state_e;

  function automatic logic is_delim(input logic [7:0] b);
    return (b == ASCII_SPACE) || (b == ASCII_DOT) || (b == ASCII_QMARK);
  endfunction

endpackage

// File: rtl/ascii_word_packer_if.sv
// Byte-in / token-out handshake bundle; master is the byte source and token sink, slave is the packer.
interface ascii_word_packer_if
  import word_pkg::*;
#(
  parameter int MAX_CHARS = MAX_CHARS_DEFAULT
);
  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic                   byte_ready;
  logic [MAX_CHARS*8-1:0] word_out;
  logic [LEN_W-1:0]       word_len;
  logic                   word_trunc;
  logic                   word_valid;
  logic                   word_ready;

  modport master (
    output byte_in, byte_valid, word_ready,
    input  byte_ready, word_out, word_len, word_trunc, word_valid
  );

  modport slave (
    input  byte_in, byte_valid, word_ready,
    output byte_ready, word_out, word_len, word_trunc, word_valid
  );
endinterface

// File: rtl/word_shift_acc.sv
// Character accumulator: shifts bytes in from the right, counts them and flags overflow.
module word_shift_acc
  import word_pkg::*;
#(
  parameter int MAX_CHARS = MAX_CHARS_DEFAULT,
  parameter int BYTE_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        clear,
  input  logic [BYTE_W-1:0]           din,
  output logic [MAX_CHARS*BYTE_W-1:0] acc,
  output logic [LEN_W-1:0]            len,
  output logic                        trunc
);
  localparam int WORD_W = MAX_CHARS * BYTE_W;

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              trunc_q, trunc_d;

  always_comb begin
    acc_d   = acc_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    if (clear) begin
      acc_d   = '0;
      len_d   = '0;
      trunc_d = 1'b0;
    end else if (push) begin
      // Once full, further characters are dropped and only remembered as truncation.
      if (len_q < LEN_W'(MAX_CHARS)) begin
        acc_d = {acc_q[WORD_W-BYTE_W-1:0], din};
        len_d = len_q + 1'b1;
      end else begin
        trunc_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
    end
  end

  assign acc   = acc_q;
  assign len   = len_q;
  assign trunc = trunc_q;

endmodule

// File: rtl/ascii_word_packer.sv
// Splits an ASCII byte stream into right-aligned word and delimiter tokens.
// Build option SPACE_SUPPRESS_EN: spaces end words but never produce a token of their own.
module ascii_word_packer
  import word_pkg::*;
#(
  parameter int MAX_CHARS = MAX_CHARS_DEFAULT,
  parameter int BYTE_W    = 8
) (
  input logic                clk,
  input logic                rst,
  ascii_word_packer_if.slave bus
);
  localparam int WORD_W = MAX_CHARS * BYTE_W;

`ifdef SPACE_SUPPRESS_EN
  localparam bit SUPPRESS_SP = 1'b1;
`else
  localparam bit SUPPRESS_SP = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_out_q, word_out_d;
  logic [LEN_W-1:0]    word_len_q, word_len_d;
  logic                word_trunc_q, word_trunc_d;
  logic                word_valid_q, word_valid_d;
  logic                pend_q, pend_d;
  logic [BYTE_W-1:0]   delim_q, delim_d;

  logic [WORD_W-1:0]   acc;
  logic [LEN_W-1:0]    acc_len;
  logic                acc_trunc;
  logic                push, clear;
  logic                byte_xfer, word_xfer, ends_word, tok_delim;

  word_shift_acc #(.MAX_CHARS(MAX_CHARS), .BYTE_W(BYTE_W)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .clear (clear),
    .din   (bus.byte_in),
    .acc   (acc),
    .len   (acc_len),
    .trunc (acc_trunc)
  );

  assign byte_xfer = bus.byte_valid && (state_q == ACCUM);
  assign word_xfer = word_valid_q && bus.word_ready;
  assign ends_word = is_delim(bus.byte_in) || (bus.byte_in == ASCII_LF);
  assign tok_delim = is_delim(bus.byte_in) && !(SUPPRESS_SP && (bus.byte_in == ASCII_SPACE));

  always_comb begin
    state_d      = state_q;
    word_out_d   = word_out_q;
    word_len_d   = word_len_q;
    word_trunc_d = word_trunc_q;
    word_valid_d = word_valid_q;
    pend_d       = pend_q;
    delim_d      = delim_q;
    push         = 1'b0;
    clear        = 1'b0;
    unique case (state_q)
      ACCUM: begin
        if (byte_xfer) begin
          if (ends_word && (acc_len != '0)) begin
            // The word moves into the output register, so the accumulator frees up now.
            state_d      = EMIT_WORD;
            word_out_d   = acc;
            word_len_d   = acc_len;
            word_trunc_d = acc_trunc;
            word_valid_d = 1'b1;
            clear        = 1'b1;
            pend_d       = tok_delim;
            delim_d      = bus.byte_in;
          end else if (tok_delim) begin
            state_d      = EMIT_DELIM;
            word_out_d   = WORD_W'(bus.byte_in);
            word_len_d   = LEN_W'(1);
            word_trunc_d = 1'b0;
            word_valid_d = 1'b1;
          end else if (!ends_word) begin
            push = 1'b1;
          end
        end
      end
      EMIT_WORD: begin
        if (word_xfer) begin
          if (pend_q) begin
            state_d      = EMIT_DELIM;
            word_out_d   = WORD_W'(delim_q);
            word_len_d   = LEN_W'(1);
            word_trunc_d = 1'b0;
            pend_d       = 1'b0;
          end else begin
            state_d      = ACCUM;
            word_valid_d = 1'b0;
          end
        end
      end
      EMIT_DELIM: begin
        if (word_xfer) begin
          state_d      = ACCUM;
          word_valid_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      word_out_q   <= '0;
      word_len_q   <= '0;
      word_trunc_q <= 1'b0;
      word_valid_q <= 1'b0;
      pend_q       <= 1'b0;
      delim_q      <= '0;
    end else begin
      state_q      <= state_d;
      word_out_q   <= word_out_d;
      word_len_q   <= word_len_d;
      word_trunc_q <= word_trunc_d;
      word_valid_q <= word_valid_d;
      pend_q       <= pend_d;
      delim_q      <= delim_d;
    end
  end

  assign bus.byte_ready = (state_q == ACCUM);
  assign bus.word_out   = word_out_q;
  assign bus.word_len   = word_len_q;
  assign bus.word_trunc = word_trunc_q;
  assign bus.word_valid = word_valid_q;

endmodule

// File: tb/tb_ascii_word_packer.sv
// Directed and randomized bench for ascii_word_packer against a token-list reference model.
module tb_ascii_word_packer;
  logic clk = 1'b0;
  logic rst;

`ifdef SPACE_SUPPRESS_EN
  localparam bit SUPP = 1'b1;
`else
  localparam bit SUPP = 1'b0;
`endif

  ascii_word_packer_if #(.MAX_CHARS(10)) bus ();

  ascii_word_packer #(.MAX_CHARS(10), .BYTE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit rnd_rdy  = 1'b0;

  logic [84:0] got[$];
  logic [84:0] exp_q[$];
  logic [7:0]  m_cur[$];
  bit          m_trunc;

  // Token seen on the bus this cycle transfers at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && bus.word_valid && bus.word_ready)
      got.push_back({bus.word_trunc, bus.word_len, bus.word_out});
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_cur.delete();
    m_trunc = 1'b0;
  endfunction

  function automatic void m_feed(input logic [7:0] b);
    bit          d;
    logic [79:0] v;
    d = (b == 8'h20) || (b == 8'h2E) || (b == 8'h3F);
    if (d || b == 8'h0A) begin
      if (m_cur.size() > 0) begin
        v = '0;
        foreach (m_cur[i]) v = (v << 8) | 80'(m_cur[i]);
        exp_q.push_back({m_trunc, 4'(m_cur.size()), v});
      end
      m_cur.delete();
      m_trunc = 1'b0;
      if (d && !(SUPP && b == 8'h20)) exp_q.push_back({1'b0, 4'd1, 72'd0, b});
    end else if (m_cur.size() < 10) begin
      m_cur.push_back(b);
    end else begin
      m_trunc = 1'b1;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (rnd_rdy) bus.word_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = bus.byte_ready;
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b0;
    m_feed(b);
    chk("byte_accept", 96'(ok), 96'(1));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain();
    int idle = 0;
    bus.word_ready = 1'b1;
    bus.byte_valid = 1'b0;
    for (int k = 0; k < 100 && idle < 3; k++) begin
      @(negedge clk);
      idle = bus.word_valid ? 0 : idle + 1;
      @(posedge clk);
      #1;
    end
    chk("drain_done", 96'(idle >= 3), 96'(1));
  endtask

  task automatic compare_tokens(input string tag);
    int n;
    chk({tag, "_count"}, 96'(got.size()), 96'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_tok%0d", tag, i), 96'(got[i]), 96'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    rst            = 1'b1;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.word_ready = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_byte_ready", 96'(bus.byte_ready), 96'(1));
    chk("rst_word_valid", 96'(bus.word_valid), 96'(0));
    chk("rst_word_out",   96'(bus.word_out),   96'(0));
    chk("rst_word_len",   96'(bus.word_len),   96'(0));
    chk("rst_word_trunc", 96'(bus.word_trunc), 96'(0));

    // "is " with a ready sink; the word is valid the cycle after the space.
    send_str("is");
    send_byte(8'h20);
    chk("is_latency", 96'(bus.word_valid), 96'(1));
    drain();
    chk("is_word", 96'(got[0]), 96'({1'b0, 4'd2, 80'h6973}));
    if (!SUPP) chk("is_space", 96'(got[1]), 96'({1'b0, 4'd1, 80'h20}));
    compare_tokens("is");

    send_str("Samsung.");
    drain();
    chk("samsung_word", 96'(got[0]), 96'({1'b0, 4'd7, 80'h00000053616d73756e67}));
    chk("samsung_dot",  96'(got[1]), 96'({1'b0, 4'd1, 80'h2e}));
    compare_tokens("samsung");

    send_str("competitors?");
    drain();
    chk("comp_word", 96'(got[0]), 96'({1'b1, 4'd10, 80'h636f6d70657469746f72}));
    chk("comp_q",    96'(got[1]), 96'({1'b0, 4'd1, 80'h3f}));
    compare_tokens("comp");

    // Sink stalled: token must hold and input must stay blocked.
    bus.word_ready = 1'b0;
    send_str("Who?");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_valid%0d", i), 96'(bus.word_valid), 96'(1));
      chk($sformatf("stall_out%0d", i),   96'(bus.word_out),   96'(80'h57686f));
      chk($sformatf("stall_bready%0d", i), 96'(bus.byte_ready), 96'(0));
      @(posedge clk);
      #1;
    end
    drain();
    chk("who_bready_after", 96'(bus.byte_ready), 96'(1));
    chk("who_q", 96'(got[1]), 96'({1'b0, 4'd1, 80'h3f}));
    compare_tokens("who");

    // Reset mid-word discards the fragment.
    send_str("Pe");
    do_reset();
    send_str("at ");
    drain();
    chk("pe_at_word", 96'(got[0]), 96'({1'b0, 4'd2, 80'h6174}));
    compare_tokens("reset_word");

    // Reset while a token is held by a stalled sink.
    bus.word_ready = 1'b0;
    send_str("ab.");
    do_reset();
    chk("rst_emit_valid",  96'(bus.word_valid), 96'(0));
    chk("rst_emit_bready", 96'(bus.byte_ready), 96'(1));
    drain();
    compare_tokens("reset_emit");

    send_str("  .2015\n");
    drain();
    if (SUPP) chk("delims_first", 96'(got[0]), 96'({1'b0, 4'd1, 80'h2e}));
    else      chk("delims_first", 96'(got[0]), 96'({1'b0, 4'd1, 80'h20}));
    compare_tokens("delims");

    // Randomized stream with a randomly stalling sink.
    rnd_rdy = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 300; i++) begin
        int r;
        logic [7:0] b;
        r = $urandom_range(0, ph == 0 ? 19 : 39);
        case (r)
          0, 1:    b = 8'h20;
          2:       b = 8'h2E;
          3:       b = 8'h3F;
          4:       b = 8'h0A;
          default: b = 8'h61 + 8'($urandom_range(0, 25));
        endcase
        send_byte(b);
      end
      send_byte(8'h0A);
      drain();
      compare_tokens($sformatf("random%0d", ph));
    end
    rnd_rdy = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascii_word_packer.md
Name: ascii_word_packer

Overview:
- Upstream stage of the hex-key encoder; converts a serial ASCII byte stream into right-aligned, zero-padded 80-bit word vectors, one per token.
- Each word and each delimiter (space, '.', '?') is its own token, so the encoder can map both to IDs.
- Sits between the speech-to-text byte source and the hex-key encoder; the encoder's enable is driven from word_valid.

Parameters:
- MAX_CHARS, 10, maximum characters per word; word bus width is MAX_CHARS*8.
- BYTE_W, 8, input character width; fixed at 8, not to be overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- byte_in  input  8  ASCII character.
- byte_valid  input  1  byte_in valid this cycle.
- byte_ready  output  1  packer can accept a byte this cycle.
- word_out  output  MAX_CHARS*8  packed token, right-aligned; first character in the most significant occupied byte, zero-padded above.
- word_len  output  4  character count of word_out (1..MAX_CHARS).
- word_trunc  output  1  word exceeded MAX_CHARS; excess characters dropped.
- word_valid  output  1  word_out/word_len/word_trunc valid.
- word_ready  input  1  downstream accepts the token.

Behaviour:
- Byte transfer occurs when byte_valid && byte_ready. Word transfer occurs when word_valid && word_ready.
- Delimiters are 0x20, 0x2E and 0x3F. 0x0A (LF) is a flush: it emits any pending word and produces no token of its own. All other bytes are characters.
- Character accept:
  - If acc_len < MAX_CHARS: acc <= {acc[MAX-1 bytes], byte}, acc_len+1.
  - Otherwise the byte is dropped and trunc_flag is set.
- States:
  - ACCUM: byte_ready=1.
    - Character: update acc and stay in ACCUM.
    - Delimiter with acc_len>0: latch the delimiter, go to EMIT_WORD.
    - Delimiter with acc_len==0: go to EMIT_DELIM.
    - LF with acc_len>0: go to EMIT_WORD with no delimiter pending.
    - LF with acc_len==0: ignored.
  - EMIT_WORD: byte_ready=0, word_valid=1, word_out=acc, word_len=acc_len, word_trunc=trunc_flag. On transfer: clear acc, acc_len and trunc_flag, then go to EMIT_DELIM if a delimiter is pending, else ACCUM.
  - EMIT_DELIM: byte_ready=0, word_valid=1, word_out=zero-extended delimiter, word_len=1, word_trunc=0. On transfer, go to ACCUM.
- Latency: the delimiter accepted in cycle N gives word_valid in cycle N+1. Its own token appears in the cycle after the word transfers, or in N+1 if no word was pending.
- Outputs are registered and held stable while word_valid && !word_ready. No combinational path from word_ready to word_out.
- Reset values: state=ACCUM, acc=0, acc_len=0, trunc_flag=0, pending delimiter cleared, word_valid=0, word_out=0, word_len=0, word_trunc=0, byte_ready=1 from the first cycle after reset.
- Reset mid-word or mid-emit discards all partial and held data with no token emitted.
- Consecutive delimiters each produce a token (e.g. "  " gives two 0x20 tokens).
- Throughput: one token per cycle at most.
- byte_in is ignored while byte_ready=0; the source must hold it.

Optional Feature:
- Macro: SPACE_SUPPRESS_EN.
- Defined: a 0x20 delimiter ends the pending word but never generates an EMIT_DELIM token. A space with an empty accumulator is discarded. '.' and '?' still emit.
- Undefined: spaces are emitted as tokens as described above.

Decomposition:
- Package word_pkg:
  - localparams for ASCII_SPACE=8'h20, ASCII_DOT=8'h2E, ASCII_QMARK=8'h3F, ASCII_LF=8'h0A.
  - MAX_CHARS default.
  - state enum {ACCUM, EMIT_WORD, EMIT_DELIM}.
  - function is_delim(byte).
- One natural sub-module: word_shift_acc (shift-in register, length counter, saturation/trunc flag). The FSM and handshake stay in the top level.

Test Plan:
- Bytes "is " with word_ready=1 -> token 80'h...6973 len=2, next cycle token 80'h...20 len=1.
- "Samsung." -> token 80'h00000053616d73756e67 len=7 trunc=0, then 80'h...2e.
- "competitors?" (11 chars) -> word_out=80'h636f6d70657469746f72, len=10, trunc=1, then 80'h...3f. The trailing 's' is dropped.
- "Who?" with word_ready held low 5 cycles -> word_out=80'h...57686f is stable and byte_ready=0 throughout. After release: 0x3f token, then byte_ready=1.
- "Pe", rst pulse, then "at " -> only tokens 80'h...6174 and 0x20; no "Pe" fragment.
- "  ." and "2015\n":
  - Without SPACE_SUPPRESS_EN: tokens 0x20, 0x20, 0x2e, then 80'h...32303135 with no LF token.
  - With SPACE_SUPPRESS_EN: tokens 0x2e, then 80'h...32303135.
